// File: rtl/mdclcg_core.sv
// rtl/mdclcg_core.sv - dual-coupled multiplier-free LCG random-bit generator with word packer
module mdclcg_core #(
    parameter int WIDTH = 64,
    parameter int OUT_W = 32,
    parameter int RW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_x,
    input  logic [WIDTH-1:0] seed_y,
    input  logic [RW-1:0]    r1,
    input  logic [RW-1:0]    r2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic             start,
    input  logic             stop,
    output logic [OUT_W-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(OUT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_FULL
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] fx, fy;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [OUT_W-1:0] out_word_q, out_word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             step_bit;
    logic             last_step;

    // a = 2^r + 1 realised as x + (x << r); carries past WIDTH-1 drop out naturally
    always_comb begin
        fx        = x_q + (x_q << r1) + b1;
        fy        = y_q + (y_q << r2) + b2;
        step_bit  = (fx > fy);
        last_step = (cnt_q == CW'(OUT_W - 1));
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;

        if (seed_load) begin
            x_d         = seed_x;
            y_d         = seed_y;
            shreg_d     = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_GEN;
                    end
                end
                S_GEN: begin
                    // the completing step wins over stop so no finished word is lost
                    if (last_step) begin
                        x_d         = fx;
                        y_d         = fy;
                        shreg_d     = {shreg_q[OUT_W-2:0], step_bit};
                        out_word_d  = {shreg_q[OUT_W-2:0], step_bit};
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_FULL;
                    end else if (stop) begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        x_d     = fx;
                        y_d     = fy;
                        shreg_d = {shreg_q[OUT_W-2:0], step_bit};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = stop ? S_IDLE : S_GEN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
